key_event_decoder: RTL

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_event_decoder.sv | 99 +++++++++
 1 files changed

// File: rtl/key_event_decoder.sv
// Key event decoder: turns a debounced key level into press, release,
// short, long and auto-repeat strobes plus a saturating press counter.
module key_event_decoder #(
    parameter int LONG_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    localparam logic [1:0] LOCKOUT = 2'd0;
    localparam logic [1:0] IDLE    = 2'd1;
    localparam logic [1:0] PRESSED = 2'd2;
    localparam logic [1:0] LONG    = 2'd3;

    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] hold_cnt;
    logic [CNT_WIDTH-1:0] rep_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= LOCKOUT;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            unique case (state)
                // A key still down after reset must be released before it counts.
                LOCKOUT: begin
                    if (!in)
                        state <= IDLE;
                end
                IDLE: begin
                    if (in) begin
                        state       <= PRESSED;
                        hold_cnt    <= '0;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        if (press_count != 8'hFF)
                            press_count <= press_count + 8'd1;
                    end
                end
                // Release is tested first so it wins over the long threshold.
                PRESSED: begin
                    if (!in) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        short_pulse   <= 1'b1;
                        held          <= 1'b0;
                    end else if (hold_cnt == LONG_LAST) begin
                        state      <= LONG;
                        long_pulse <= 1'b1;
                        rep_cnt    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end
                LONG: begin
                    if (!in) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (rep_cnt == REP_LAST) begin
                        repeat_pulse <= 1'b1;
                        rep_cnt      <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + CNT_ONE;
                    end
                end
                default: state <= LOCKOUT;
            endcase
        end
    end

endmodule
